// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the register-mapped peripheral bus.
// Holds default bus widths (shared with wb_gpio), the master FSM state
// encoding and the default bus-timeout length.
package wb_pkg;

   localparam int unsigned WB_ADR_WIDTH        = 32;
   localparam int unsigned WB_DAT_WIDTH        = 32;
   localparam int unsigned WBM_TIMEOUT_DEFAULT = 255;
   localparam int unsigned WBM_CNT_WIDTH       = 16;

   // Master FSM states; encoding 2'd3 is unused and recovers to idle.
   typedef enum logic [1:0] {
      WBM_IDLE = 2'd0,
      WBM_BUS  = 2'd1,
      WBM_RESP = 2'd2
   } wbm_state_t;

endpackage : wb_pkg

// File: rtl/wb_master_seq.sv
// Single-outstanding Wishbone classic master.
// Converts one valid/ready request into one Wishbone read or write cycle and
// returns read data (or a timeout error) on a valid/ready response port.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o  request handshake (ready = FSM idle)
//   req_we_i/adr_i/dat_i     request payload
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_dat_o/rsp_err_o      read data (0 for writes/errors), timeout flag
//   wb_*                     Wishbone classic master interface
module wb_master_seq
   import wb_pkg::*;
#(
   parameter int unsigned wb_adr_width   = WB_ADR_WIDTH,
   parameter int unsigned wb_dat_width   = WB_DAT_WIDTH,
   parameter int unsigned timeout_cycles = WBM_TIMEOUT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_we_i,
   input  logic [wb_adr_width-1:0] req_adr_i,
   input  logic [wb_dat_width-1:0] req_dat_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [wb_dat_width-1:0] rsp_dat_o,
   output logic                    rsp_err_o,
   output logic [wb_adr_width-1:0] wb_adr_o,
   output logic [wb_dat_width-1:0] wb_dat_o,
   output logic                    wb_we_o,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   input  logic [wb_dat_width-1:0] wb_dat_i,
   input  logic                    wb_ack_i
);

   localparam bit                       TIMEOUT_EN = (timeout_cycles != 0);
   localparam logic [WBM_CNT_WIDTH-1:0] TO_LAST    = WBM_CNT_WIDTH'(timeout_cycles - 1);
   localparam logic [WBM_CNT_WIDTH-1:0] CNT_MAX    = '1;

   wbm_state_t               state;
   logic [WBM_CNT_WIDTH-1:0] to_cnt;

   assign req_ready_o = (state == WBM_IDLE);

   // FSM, timeout counter and capture registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= WBM_IDLE;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_dat_o   <= '0;
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_adr_o    <= '0;
         wb_dat_o    <= '0;
         to_cnt      <= '0;
      end else begin
         case (state)
            WBM_IDLE: begin
               if (req_valid_i) begin
                  wb_adr_o <= req_adr_i;
                  wb_dat_o <= req_dat_i;
                  wb_we_o  <= req_we_i;
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  to_cnt   <= '0;
                  state    <= WBM_BUS;
               end
            end

            WBM_BUS: begin
               if (to_cnt != CNT_MAX) begin
                  to_cnt <= to_cnt + WBM_CNT_WIDTH'(1);
               end
               // Ack is checked first so an ack on the last allowed cycle wins.
               if (wb_stb_o && wb_ack_i) begin
                  rsp_dat_o   <= wb_we_o ? '0 : wb_dat_i;
                  rsp_err_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  wb_cyc_o    <= 1'b0;
                  wb_stb_o    <= 1'b0;
                  state       <= WBM_RESP;
               end else if (TIMEOUT_EN && (to_cnt == TO_LAST)) begin
                  rsp_dat_o   <= '0;
                  rsp_err_o   <= 1'b1;
                  rsp_valid_o <= 1'b1;
                  wb_cyc_o    <= 1'b0;
                  wb_stb_o    <= 1'b0;
                  state       <= WBM_RESP;
               end
            end

            WBM_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  state       <= WBM_IDLE;
               end
            end

            default: begin
               rsp_valid_o <= 1'b0;
               wb_cyc_o    <= 1'b0;
               wb_stb_o    <= 1'b0;
               state       <= WBM_IDLE;
            end
         endcase
      end
   end

endmodule : wb_master_seq

// File: tb/tb_wb_master_seq.sv
// Self-checking bench for wb_master_seq with a small Wishbone slave model
// (four word registers at 0x0/0x4/0x8/0xC, programmable ack delay).
module tb_wb_master_seq;
   import wb_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 4;
   localparam logic [15:0] NEVER = 16'hFFFF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic          req_we_i = 1'b0;
   logic [AW-1:0] req_adr_i = '0;
   logic [DW-1:0] req_dat_i = '0;
   logic          rsp_valid_o;
   logic          rsp_ready_i = 1'b1;
   logic [DW-1:0] rsp_dat_o;
   logic          rsp_err_o;
   logic [AW-1:0] wb_adr_o;
   logic [DW-1:0] wb_dat_o;
   logic          wb_we_o;
   logic          wb_cyc_o;
   logic          wb_stb_o;
   logic [DW-1:0] wb_dat_i;
   logic          wb_ack_i;

   always #5 clk = ~clk;

   wb_master_seq #(
      .wb_adr_width  (AW),
      .wb_dat_width  (DW),
      .timeout_cycles(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .req_we_i   (req_we_i),
      .req_adr_i  (req_adr_i),
      .req_dat_i  (req_dat_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_ready_i(rsp_ready_i),
      .rsp_dat_o  (rsp_dat_o),
      .rsp_err_o  (rsp_err_o),
      .wb_adr_o   (wb_adr_o),
      .wb_dat_o   (wb_dat_o),
      .wb_we_o    (wb_we_o),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_dat_i   (wb_dat_i),
      .wb_ack_i   (wb_ack_i)
   );

   // Slave model: registered, single-cycle ack after slave_delay stb cycles.
   logic [DW-1:0] mem [4];
   logic [15:0]   slave_delay = 16'd0;
   logic [15:0]   scnt;
   logic          sack;
   logic [DW-1:0] sdat;

   assign wb_ack_i = sack;
   assign wb_dat_i = sdat;

   always @(posedge clk) begin
      if (rst) begin
         sack <= 1'b0;
         scnt <= '0;
         sdat <= '0;
         for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else if (sack) begin
         sack <= 1'b0;
         scnt <= '0;
      end else if (wb_cyc_o && wb_stb_o) begin
         if (scnt == slave_delay) begin
            sack <= 1'b1;
            scnt <= '0;
            if (wb_we_o) mem[wb_adr_o[3:2]] <= wb_dat_o;
            else         sdat <= mem[wb_adr_o[3:2]];
         end else begin
            scnt <= scnt + 16'd1;
         end
      end else begin
         scnt <= '0;
      end
   end

   // Scoreboard
   typedef struct packed {
      logic [DW-1:0] dat;
      logic          err;
   } rsp_t;

   rsp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      rsp_t e;
      if (!rst && rsp_valid_o === 1'b1 && rsp_ready_i) begin
         if (sb.size() == 0) begin
            check("unexpected_rsp", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("rsp_dat", 64'(rsp_dat_o), 64'(e.dat));
            check("rsp_err", 64'(rsp_err_o), 64'(e.err));
         end
      end
   end

   // One complete transaction through the scoreboard.
   task automatic send(input int idx, input logic we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input logic [15:0] dly,
                       input logic [DW-1:0] edat, input logic eerr);
      int n;
      slave_delay = dly;
      rsp_ready_i = 1'b1;
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_adr_i   = adr;
      req_dat_i   = dat;
      n = 0;
      @(negedge clk);
      while (!req_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("vec%0d_ready", idx), 64'(req_ready_o), 64'd1);
      @(posedge clk);
      sb.push_back('{dat: edat, err: eerr});
      #1 req_valid_i = 1'b0;
      check($sformatf("vec%0d_adr", idx), 64'(wb_adr_o), 64'(adr));
      check($sformatf("vec%0d_we", idx), 64'(wb_we_o), 64'(we));
      if (we) check($sformatf("vec%0d_wdat", idx), 64'(wb_dat_o), 64'(dat));
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("vec%0d_rsp_seen", idx), 64'(sb.size() == 0), 64'd1);
      sb.delete();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      logic [15:0]   dly;
      logic [DW-1:0] edat;
      logic          eerr;
   } vec_t;

   vec_t vecs[10];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      int n;
      int stb_cnt;

      vecs[0] = '{1'b1, 32'h8, 32'hFF,       16'd0, 32'h0,        1'b0};
      vecs[1] = '{1'b1, 32'h0, 32'h3C,       16'd0, 32'h0,        1'b0};
      vecs[2] = '{1'b0, 32'h0, 32'h0,        16'd0, 32'h3C,       1'b0};
      vecs[3] = '{1'b0, 32'h4, 32'h0,        16'd1, 32'hA5,       1'b0};
      vecs[4] = '{1'b0, 32'h8, 32'h0,        16'd2, 32'hFF,       1'b0}; // ack on last cycle
      vecs[5] = '{1'b0, 32'h4, 32'h0,        16'd3, 32'h0,        1'b1}; // ack one cycle too late
      vecs[6] = '{1'b1, 32'h4, 32'h11,       NEVER, 32'h0,        1'b1};
      vecs[7] = '{1'b0, 32'h4, 32'h0,        16'd0, 32'hA5,       1'b0};
      vecs[8] = '{1'b1, 32'hC, 32'h12345678, 16'd1, 32'h0,        1'b0};
      vecs[9] = '{1'b0, 32'hC, 32'h0,        16'd0, 32'h12345678, 1'b0};

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 64'(req_ready_o), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("rst_rsp_err",   64'(rsp_err_o),   64'd0);
      check("rst_rsp_dat",   64'(rsp_dat_o),   64'd0);
      check("rst_cyc",       64'(wb_cyc_o),    64'd0);
      check("rst_stb",       64'(wb_stb_o),    64'd0);
      check("rst_we",        64'(wb_we_o),     64'd0);
      check("rst_adr",       64'(wb_adr_o),    64'd0);
      check("rst_dat",       64'(wb_dat_o),    64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Write latency with a one-cycle-ack slave
      slave_delay = 16'd0;
      rsp_ready_i = 1'b1;
      req_valid_i = 1'b1;
      req_we_i    = 1'b1;
      req_adr_i   = 32'h4;
      req_dat_i   = 32'hA5;
      check("lat_ready_idle", 64'(req_ready_o), 64'd1);
      @(posedge clk);
      sb.push_back('{dat: 32'h0, err: 1'b0});
      #1 req_valid_i = 1'b0;
      check("lat_e0_cyc", 64'(wb_cyc_o), 64'd1);
      check("lat_e0_stb", 64'(wb_stb_o), 64'd1);
      check("lat_e0_adr", 64'(wb_adr_o), 64'h4);
      check("lat_e0_dat", 64'(wb_dat_o), 64'hA5);
      check("lat_e0_we",  64'(wb_we_o),  64'd1);
      check("lat_e0_ready", 64'(req_ready_o), 64'd0);
      @(posedge clk);
      #1;
      check("lat_e1_stb",   64'(wb_stb_o),    64'd1);
      check("lat_e1_valid", 64'(rsp_valid_o), 64'd0);
      @(posedge clk);
      #1;
      check("lat_e2_valid", 64'(rsp_valid_o), 64'd1);
      check("lat_e2_cyc",   64'(wb_cyc_o),    64'd0);
      check("lat_e2_stb",   64'(wb_stb_o),    64'd0);
      @(posedge clk);
      #1;
      check("lat_e3_valid", 64'(rsp_valid_o), 64'd0);
      check("lat_e3_ready", 64'(req_ready_o), 64'd1);
      check("lat_sb_empty", 64'(sb.size()), 64'd0);
      check("lat_slave_reg", 64'(mem[1]), 64'hA5);
      sb.delete();

      // Table-driven transactions
      for (int i = 0; i < 10; i++) begin
         send(i, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].dly,
              vecs[i].edat, vecs[i].eerr);
      end

      // Timeout: slave never acks, stb must be high exactly TO cycles
      slave_delay = NEVER;
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_adr_i   = 32'h8;
      @(posedge clk);
      sb.push_back('{dat: 32'h0, err: 1'b1});
      #1 req_valid_i = 1'b0;
      n = 0;
      stb_cnt = 0;
      while (n < 20) begin
         @(negedge clk);
         if (rsp_valid_o) break;
         if (wb_stb_o) stb_cnt++;
         n++;
      end
      check("to_stb_cycles", 64'(stb_cnt), 64'(TO));
      check("to_valid", 64'(rsp_valid_o), 64'd1);
      check("to_err",   64'(rsp_err_o),   64'd1);
      check("to_dat",   64'(rsp_dat_o),   64'd0);
      check("to_ready_busy", 64'(req_ready_o), 64'd0);
      @(posedge clk);
      #1 rsp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      check("to_ready_after", 64'(req_ready_o), 64'd1);
      check("to_valid_after", 64'(rsp_valid_o), 64'd0);
      check("to_sb_empty", 64'(sb.size()), 64'd0);
      sb.delete();

      // Backpressure with a second request waiting
      slave_delay = 16'd0;
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_adr_i   = 32'h8;
      @(posedge clk);
      sb.push_back('{dat: 32'hFF, err: 1'b0});
      #1 req_valid_i = 1'b0;
      n = 0;
      while (!rsp_valid_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      req_valid_i = 1'b1;
      req_adr_i   = 32'h0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("bp%0d_valid", k), 64'(rsp_valid_o), 64'd1);
         check($sformatf("bp%0d_dat", k),   64'(rsp_dat_o),   64'hFF);
         check($sformatf("bp%0d_err", k),   64'(rsp_err_o),   64'd0);
         check($sformatf("bp%0d_ready", k), 64'(req_ready_o), 64'd0);
         check($sformatf("bp%0d_cyc", k),   64'(wb_cyc_o),    64'd0);
      end
      @(posedge clk);
      #1 rsp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      check("bp_hs_ready", 64'(req_ready_o), 64'd1);
      check("bp_hs_cyc",   64'(wb_cyc_o),    64'd0);
      check("bp_hs_valid", 64'(rsp_valid_o), 64'd0);
      sb.push_back('{dat: 32'h3C, err: 1'b0});
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      check("bp_second_cyc", 64'(wb_cyc_o), 64'd1);
      check("bp_second_adr", 64'(wb_adr_o), 64'h0);
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("bp_sb_empty", 64'(sb.size()), 64'd0);
      sb.delete();
      @(posedge clk);
      #1;

      // Reset in the middle of a bus cycle
      slave_delay = NEVER;
      rsp_ready_i = 1'b1;
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_adr_i   = 32'h4;
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      check("mid_stb", 64'(wb_stb_o), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("mid_rst_cyc",   64'(wb_cyc_o),    64'd0);
      check("mid_rst_stb",   64'(wb_stb_o),    64'd0);
      check("mid_rst_valid", 64'(rsp_valid_o), 64'd0);
      check("mid_rst_ready", 64'(req_ready_o), 64'd1);
      repeat (6) @(posedge clk);
      #1;
      check("mid_rst_quiet", 64'(rsp_valid_o), 64'd0);
      send(20, 1'b1, 32'h4, 32'h77, 16'd0, 32'h0, 1'b0);
      send(21, 1'b0, 32'h4, 32'h0,  16'd0, 32'h77, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_wb_master_seq
